// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem request at a time, buffers the
// responses in a small FIFO and hands {pc, inst} to decode via valid/ready.
module fetch_unit #(
  parameter int DBITS     = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] pcIn,
  output logic             pcAdvance,
  input  logic             flush,
  output logic             imemReq,
  output logic [DBITS-1:0] imemAddr,
  input  logic             imemAck,
  input  logic [DBITS-1:0] imemData,
  output logic [DBITS-1:0] instOut,
  output logic [DBITS-1:0] instPc,
  output logic             instValid,
  input  logic             instReady
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = BUF_DEPTH[AW:0];

  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]       state;
  logic [AW:0]      count;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DBITS-1:0] pc_latch;
  logic [DBITS-1:0] inst_mem [BUF_DEPTH];
  logic [DBITS-1:0] pc_mem   [BUF_DEPTH];

  logic issue;
  logic push;
  logic pop;

  assign issue     = (state == ISSUE) && (count < DEPTH_C) && !flush;
  assign push      = (state == WAIT) && imemAck && !flush;
  assign instValid = (count != '0);
  assign pop       = instValid && instReady && !flush;
  assign pcAdvance = issue;
  assign instOut   = inst_mem[rd_ptr];
  assign instPc    = pc_mem[rd_ptr];

  // Request FSM: an ack in DROP belongs to a request killed by a redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ISSUE;
      imemReq  <= 1'b0;
      imemAddr <= '0;
      pc_latch <= '0;
    end else begin
      imemReq <= issue;
      if (issue) begin
        imemAddr <= pcIn;
        pc_latch <= pcIn;
      end
      case (state)
        ISSUE:   if (issue) state <= WAIT;
        WAIT: begin
          if (imemAck)    state <= ISSUE;
          else if (flush) state <= DROP;
        end
        DROP:    if (imemAck) state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end
  end

  // Instruction FIFO; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= imemData;
        pc_mem[wr_ptr]   <= pc_latch;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenario table, reset-abort sequence and a
// randomized run, all checked against a queue-based model of the fetch stage.
module tb_fetch_unit;
  localparam int DBITS = 32;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DBITS-1:0]  pcIn;
  logic              pcAdvance;
  logic              flush;
  logic              imemReq;
  logic [DBITS-1:0]  imemAddr;
  logic              imemAck;
  logic [DBITS-1:0]  imemData;
  logic [DBITS-1:0]  instOut;
  logic [DBITS-1:0]  instPc;
  logic              instValid;
  logic              instReady;

  fetch_unit #(.DBITS(DBITS), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pcIn(pcIn), .pcAdvance(pcAdvance), .flush(flush),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instOut(instOut), .instPc(instPc), .instValid(instValid), .instReady(instReady)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct {
    int lat; int ready_at; int flush_at; logic [31:0] tgt; int ncyc; int nexp;
    logic [2:0][31:0] epc; logic [2:0][31:0] einst;
  } vec_t;

  ent_t        q[$];
  ent_t        dlv[$];
  bit          inflight, doomed, exp_req, ack_next, rand_lat;
  logic [31:0] pc_l, exp_addr, pc, tgt, rsp_addr;
  int          rsp_left, lat;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tbl[5];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h40) >> 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    inflight = 0; doomed = 0; exp_req = 0;
    pc = 32'h40; rsp_left = -1; ack_next = 0;
  endtask

  // One clock cycle: check/advance model at negedge, drive inputs after posedge.
  task automatic tick();
    bit   adv;
    ent_t e;
    @(negedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      adv = !inflight && (q.size() < DEPTH) && !flush;
      chk("pcAdvance", {31'b0, pcAdvance}, {31'b0, adv});
      chk("instValid", {31'b0, instValid}, {31'b0, q.size() > 0});
      if (q.size() > 0) begin
        chk("instPc", instPc, q[0].pc);
        chk("instOut", instOut, q[0].inst);
      end
      chk("imemReq", {31'b0, imemReq}, {31'b0, exp_req});
      if (exp_req) chk("imemAddr", imemAddr, exp_addr);
      if (instValid && instReady && !flush) begin
        e.pc = instPc; e.inst = instOut; dlv.push_back(e);
      end
      if (q.size() > 0 && instReady && !flush) e = q.pop_front();
      if (imemAck && inflight) begin
        if (!doomed && !flush) begin
          e.pc = pc_l; e.inst = memf(pc_l); q.push_back(e);
        end
        inflight = 0; doomed = 0;
      end else if (inflight && flush) begin
        doomed = 1;
      end
      if (flush) q.delete();
      exp_req = adv;
      if (adv) begin
        inflight = 1; doomed = 0; pc_l = pcIn; exp_addr = pcIn;
      end
      if (flush) pc = tgt;
      else if (pcAdvance) pc = pc + 32'd4;
      ack_next = 0;
      if (imemReq) begin
        rsp_addr = imemAddr;
        rsp_left = rand_lat ? int'($urandom_range(1, 4)) : lat;
      end
      if (rsp_left > 0) begin
        rsp_left--;
        if (rsp_left == 0) begin ack_next = 1; rsp_left = -1; end
      end
    end
    @(posedge clk); #1;
    pcIn     = pc;
    imemAck  = ack_next;
    imemData = ack_next ? memf(rsp_addr) : 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 0; instReady = 0; imemAck = 0; imemData = 0;
    tgt = 0; pcIn = 32'h40;
    model_clear();
    #1;
    chk("rst_imemReq", {31'b0, imemReq}, 32'h0);
    chk("rst_imemAddr", imemAddr, 32'h0);
    chk("rst_instValid", {31'b0, instValid}, 32'h0);
    chk("rst_instPc", instPc, 32'h0);
    chk("rst_instOut", instOut, 32'h0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    flush = 0; instReady = 0; imemAck = 0; imemData = 0; pcIn = 32'h40;
    rand_lat = 0; lat = 1;
    // lat, ready_at, flush_at, tgt, ncyc, nexp, expected pcs, expected insts
    tbl[0] = '{1, 0, -1, 32'h0, 10, 3, {32'h48, 32'h44, 32'h40}, {32'hA2, 32'hA1, 32'hA0}};
    tbl[1] = '{3, 0, 7, 32'h80, 16, 2, {32'h0, 32'h80, 32'h40}, {32'h0, 32'hB0, 32'hA0}};
    tbl[2] = '{1, 12, -1, 32'h0, 18, 3, {32'h48, 32'h44, 32'h40}, {32'hA2, 32'hA1, 32'hA0}};
    tbl[3] = '{1, 10, 8, 32'h100, 14, 1, {32'h0, 32'h0, 32'h100}, {32'h0, 32'h0, 32'hD0}};
    tbl[4] = '{1, 5, -1, 32'h0, 10, 3, {32'h48, 32'h44, 32'h40}, {32'hA2, 32'hA1, 32'hA0}};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      rand_lat = 0;
      lat = tbl[i].lat;
      dlv.delete();
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        instReady = (c >= tbl[i].ready_at);
        flush     = (c == tbl[i].flush_at);
        tgt       = tbl[i].tgt;
        tick();
      end
      flush = 0;
      chk($sformatf("vec%0d_count", i), dlv.size(), tbl[i].nexp);
      for (int k = 0; k < tbl[i].nexp; k++) begin
        if (k < dlv.size()) begin
          chk($sformatf("vec%0d_pc%0d", i, k), dlv[k].pc, tbl[i].epc[k]);
          chk($sformatf("vec%0d_inst%0d", i, k), dlv[k].inst, tbl[i].einst[k]);
        end
      end
    end

    // Reset asserted while a request is outstanding; stale ack after release.
    do_reset();
    lat = 3; instReady = 1; dlv.delete();
    tick();
    chk("abort_req_before", {31'b0, imemReq}, 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_imemReq", {31'b0, imemReq}, 32'h0);
    chk("abort_imemAddr", imemAddr, 32'h0);
    chk("abort_instValid", {31'b0, instValid}, 32'h0);
    chk("abort_instPc", instPc, 32'h0);
    chk("abort_instOut", instOut, 32'h0);
    tick();
    reset = 1'b1;
    imemAck = 1'b1; imemData = 32'hDEAD;
    for (int c = 0; c < 6; c++) tick();
    chk("abort_count", dlv.size(), 1);
    if (dlv.size() > 0) begin
      chk("abort_first_pc", dlv[0].pc, 32'h40);
      chk("abort_first_inst", dlv[0].inst, 32'hA0);
    end

    // Randomized traffic: ready, redirects and ack latency all vary.
    do_reset();
    rand_lat = 1;
    for (int c = 0; c < 3000; c++) begin
      instReady = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tgt       = 32'h40 + (32'($urandom_range(0, 63)) << 2);
      tick();
    end
    flush = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that consumes the program counter produced by the PC register logic and retrieves instructions from instruction memory over a request/acknowledge interface. It holds fetched instructions in a small FIFO and presents them, paired with their PC, to decode through a valid/ready handshake. It also tells the PC logic when to advance (`pcAdvance`) and handles control-flow redirects by flushing in-flight and buffered instructions.

## Interface
- DBITS, 32, data/address width
- BUF_DEPTH, 2, instruction FIFO entries (power of two, ≥2)

- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- pcIn  in  DBITS  current PC from PC logic (byte address)
- pcAdvance  out  1  combinational; PC logic loads next PC at the edge where this is high
- flush  in  1  redirect; PC logic loads the target at this same edge
- imemReq  out  1  registered, single-cycle request pulse
- imemAddr  out  DBITS  registered; address of the outstanding request
- imemAck  in  1  one-cycle response strobe, ≥1 cycle after imemReq
- imemData  in  DBITS  instruction, valid with imemAck
- instOut  out  DBITS  FIFO head instruction
- instPc  out  DBITS  FIFO head PC
- instValid  out  1  FIFO non-empty
- instReady  in  1  decode accepts head when instValid && instReady

## Operation
- FSM states: ISSUE, WAIT, DROP. At most one memory request outstanding.
- issue = (state==ISSUE) && (count < BUF_DEPTH) && !flush. pcAdvance = issue.
- Issue edge: imemReq<=1 for one cycle, imemAddr<=pcIn, pcLatch<=pcIn, ISSUE→WAIT.
- WAIT, imemAck, !flush: push {pcLatch, imemData}, →ISSUE.
- WAIT, flush, !imemAck: →DROP. WAIT, flush && imemAck: data discarded, →ISSUE.
- DROP: imemAck discards data, →ISSUE. A flush in DROP stays in DROP.
- ISSUE with flush: no issue, stays ISSUE; next cycle fetches from the redirected pcIn.
- imemAck in ISSUE is ignored (e.g. stray ack after reset).
- flush empties the FIFO at that edge (count<=0); a pop that cycle is void.
- Pop on instValid && instReady && !flush. Push and pop in the same cycle are both honoured; count unchanged.
- Full is impossible at push time: issue requires count < BUF_DEPTH and only one request is in flight.
- Pointers wrap modulo BUF_DEPTH; count is $clog2(BUF_DEPTH)+1 bits.
- pcIn + 4 arithmetic lives in the PC logic; this block never modifies PC values.

## Timing
- Reset (async assert, sync release): state ISSUE, count 0, pointers 0, imemReq 0, imemAddr 0, instOut 0, instPc 0, instValid 0. pcAdvance evaluates to 1 in the first cycle after release.
- Reset mid-WAIT aborts the request and ignores its late ack. The first instruction after reset comes from pcIn at release.
- Issue-to-decode latency: imemReq is high in cycle N+1 after the issue edge N. With ack in cycle N+1+L (L≥1), instValid rises in cycle N+2+L.
- Throughput with L=1: one instruction per 3 cycles (ISSUE→WAIT→ack).
- instOut/instPc are registered FIFO storage reads. They are don't-care when instValid=0 (except after reset, when they are 0).
- flush takes effect at its edge: instValid=0 the following cycle.

## Test plan
- Streaming: reset released with pcIn model starting at 0x40, L=1, instReady=1, mem[0x40/44/48]=0xA0/A1/A2 → instPc/instOut = 0x40/A0, 0x44/A1, 0x48/A2; pcAdvance pulses once per fetch.
- Backpressure: instReady=0 → exactly two fetches (0x40, 0x44), then imemReq and pcAdvance stay 0 and count=2. Raise instReady → head pops, and 0x48 is requested on the next cycle.
- Flush during WAIT: L=3, flush while 0x44 is outstanding, PC redirected to 0x80 → ack for 0x44 dropped (DROP state), next delivered instPc=0x80.
- Flush with full FIFO and instValid=1 → instValid=0 the next cycle, count=0, then fetch resumes at the redirect target 0x100.
- Simultaneous push/pop: count=1, ack and pop in the same cycle → count stays 1, order preserved (0x44 then 0x48).
- Async reset asserted mid-WAIT → all outputs 0 immediately. Ack arriving after release is ignored, and the first instPc equals pcIn at release (0x40).
